// File: rtl/alu_pkg.sv
// Shared types for the ALU execute-to-writeback path: opcodes, the beat state
// and the default-width FIFO entry layout.
package alu_pkg;

  localparam int ALU_N      = 8;
  localparam int ALU_REG_AW = 3;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_AND = 3'b001,
    OP_SUB = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_MUL = 3'b101,
    OP_DIV = 3'b110,
    OP_SLT = 3'b111
  } alu_op_e;

  typedef enum logic {
    S_LO = 1'b0,
    S_HI = 1'b1
  } beat_state_e;

  typedef struct packed {
    logic [2*ALU_N-1:0]    result;
    alu_op_e               op;
    logic [ALU_REG_AW-1:0] dest;
  } entry_t;

endpackage

// File: rtl/alu_wb_buffer_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head and an occupancy count.
// Push is ignored when full and pop is ignored when empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the count alone says which words are meaningful.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/alu_wb_buffer.sv
// Execute-to-writeback buffer: queues 2N-bit ALU results and emits N-bit
// register-file write beats, splitting multiply results into low then high.
module alu_wb_buffer
  import alu_pkg::*;
#(
  parameter int N      = ALU_N,
  parameter int DEPTH  = 4,
  parameter int REG_AW = ALU_REG_AW
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2*N-1:0]           in_result,
  input  logic [2:0]               in_op,
  input  logic [REG_AW-1:0]        in_dest,
  output logic                     wb_valid,
  input  logic                     wb_ready,
  output logic [N-1:0]             wb_data,
  output logic [REG_AW-1:0]        wb_addr,
  output logic                     wb_hi,
  output logic                     wb_carry,
  output logic                     wb_zero,
  output logic [$clog2(DEPTH):0]   occupancy
);

  typedef struct packed {
    logic [2*N-1:0]    result;
    alu_op_e           op;
    logic [REG_AW-1:0] dest;
  } wb_entry_t;

  wb_entry_t   push_entry, head;
  beat_state_e state_q, state_d;
  logic        live_q;
  logic        full, empty, push, pop, handshake;

  // in_ready stays low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) live_q <= 1'b0;
    else        live_q <= 1'b1;
  end

  assign push_entry = '{result: in_result, op: alu_op_e'(in_op), dest: in_dest};
  assign in_ready   = live_q && !full;
  assign push       = in_valid && in_ready;
  assign wb_valid   = !empty;
  assign handshake  = wb_valid && wb_ready;

  sync_fifo #(
    .WIDTH ($bits(wb_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (push_entry),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (occupancy)
  );

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    if (handshake) begin
      unique case (state_q)
        S_LO: begin
          if (head.op == OP_MUL) state_d = S_HI;
          else                   pop     = 1'b1;
        end
        S_HI: begin
          pop     = 1'b1;
          state_d = S_LO;
        end
        default: state_d = S_LO;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_LO;
    else        state_q <= state_d;
  end

  // Beat fields are forced to zero whenever nothing is presented.
  always_comb begin
    wb_data  = '0;
    wb_addr  = '0;
    wb_hi    = 1'b0;
    wb_carry = 1'b0;
    wb_zero  = 1'b0;
    if (wb_valid) begin
      wb_zero = (head.result == '0);
      if (state_q == S_HI) begin
        wb_data = head.result[2*N-1:N];
        wb_addr = head.dest + 1'b1;
        wb_hi   = 1'b1;
      end else begin
        wb_data  = head.result[N-1:0];
        wb_addr  = head.dest;
        wb_carry = (head.op == OP_ADD) && head.result[N];
      end
    end
  end

endmodule

// File: doc/alu_wb_buffer.md
# alu_wb_buffer

Execute-to-writeback stage directly downstream of the ALU core. Captures each 2N-bit ALU result with its opcode and destination register into a small FIFO, then emits register-file write beats over an N-bit port under a valid/ready handshake. A multiply result is split into two beats: low half, then high half. All other results are one low-half beat. Decouples ALU issue from register-file write-port availability.

## Interface
Parameters:
- N, 8, ALU operand width; write-beat data width
- DEPTH, 4, FIFO entries; power of two, ≥2
- REG_AW, 3, register address width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  ALU result valid
- in_ready  out  1  buffer can accept (FIFO not full)
- in_result  in  2N  ALU result
- in_op  in  3  ALU opcode that produced in_result
- in_dest  in  REG_AW  destination register
- wb_valid  out  1  write beat valid
- wb_ready  in  1  register file accepts beat
- wb_data  out  N  beat data
- wb_addr  out  REG_AW  beat register address
- wb_hi  out  1  beat is the high half of a multiply
- wb_carry  out  1  in_result[N] of an add (op 000); 0 for every other op and on hi beats
- wb_zero  out  1  full 2N-bit result == 0; same value on both beats of a multiply
- occupancy  out  $clog2(DEPTH)+1  entries currently held

## Operation
- Reset is asynchronous and active-low: clk is the single clock, and rst_n asserted low clears the FIFO immediately. The beat state goes to S_LO.
- Output values while rst_n is low: in_ready=0, wb_valid=0, occupancy=0, and wb_data/wb_addr/wb_hi/wb_carry/wb_zero=0. From the first clk edge after release, in_ready=1.
- Push: on a clk edge where in_valid && in_ready, the entry {in_result, in_op, in_dest} is written at wr_ptr, and wr_ptr advances modulo DEPTH.
- in_ready = (occupancy != DEPTH). It depends only on occupancy and is independent of wb_ready.
- The head entry is presented first-word-fall-through. wb_valid = (occupancy != 0).
- Beat FSM has two states:
  - S_LO: wb_data = result[N-1:0], wb_addr = dest, wb_hi = 0.
  - S_HI: wb_data = result[2N-1:N], wb_addr = dest+1 mod 2^REG_AW (wraps 7→0 at REG_AW=3), wb_hi = 1.
- FSM transitions:
  - In S_LO, on a handshake (wb_valid && wb_ready) with op == 101: go to S_HI, no pop.
  - In S_LO, on a handshake with any other op: pop the entry and stay in S_LO.
  - In S_HI, on a handshake: pop the entry and go to S_LO.
  - With no handshake, state and outputs hold.
- Push and pop on the same edge: both occur, and occupancy is unchanged. When full, no push occurs even if a pop happens that edge; in_ready re-asserts the following cycle.
- Once wb_valid is asserted, beat fields must stay stable until the handshake completes.
- Unknown or default opcodes are treated as single-beat.
- A reset asserted mid-multiply discards the pending high beat and all queued entries.

## Timing
- Latency: an entry pushed at edge k into an empty buffer drives wb_valid=1 from just after edge k (the cycle between edges k and k+1).
- Throughput:
  - One beat per cycle when wb_ready is held high.
  - A multiply occupies the port for 2 cycles.
  - Sustained input at one single-beat result per cycle never stalls, for any DEPTH ≥ 2.
- occupancy is registered and updates at the edge of each push or pop.

## Structure
- Shared package alu_pkg holds:
  - the opcode enum (ADD=000, AND=001, SUB=010, OR=011, XOR=100, MUL=101, DIV=110, SLT=111)
  - the beat-state enum {S_LO, S_HI}
  - the entry struct {result, op, dest}
- One sub-module is natural: sync_fifo, parameterised by width and DEPTH. It provides push/pop, full/empty and count, with the head visible combinationally.
- alu_wb_buffer adds the beat FSM and flag logic around sync_fifo.

## Test plan
- Reset: hold rst_n=0 mid-stream, then release. All outputs read 0 during reset; in_ready=1 and occupancy=0 from the first edge after release.
- Add: push result 16'h0105, op 000, dest 2, with wb_ready=1. Expect one beat: wb_data=05, wb_addr=2, wb_carry=1, wb_zero=0, wb_hi=0; then wb_valid=0.
- Multiply with wrap: push 16'hABCD, op 101, dest 7. Expect beat 1 = CD@7, wb_hi=0; beat 2 = AB@0, wb_hi=1; one pop, after beat 2.
- Full/backpressure: wb_ready=0, push DEPTH entries. in_ready drops with occupancy=4; a 5th in_valid is not accepted. Raise wb_ready: entries drain in order and in_ready re-asserts one cycle after the first pop.
- Zero flag: push 16'h0000, op 010, dest 1. Expect wb_zero=1, wb_carry=0, single beat.
- Reset mid-multiply: assert rst_n low after the low beat of a MUL is accepted. Expect no high beat after release, occupancy=0, and FSM in S_LO.
